info_bus_source: RTL and testbench
==================================

Name: info_bus_source

Overview:
- Head of the video pipeline; creates the 69-bit info bus that every downstream stage (grab detection, hold rendering, etc.) consumes and re-delays.
- Generates 1024x768 XVGA raster timing (hcount, vcount, hsync, vsync, blank) on the 65 MHz pixel clock.
- Samples user hand positions and grab buttons once per frame, clamps them and packs them into the bus so all stages see a frame-stable user state.
- Drives existsout low: no object exists at pipeline entry.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_SYNC_START, 1048, first hcount with hsync asserted
- H_SYNC_END, 1184, first hcount after hsync
- H_TOTAL, 1344, pixels per line (hcount wraps at H_TOTAL-1)
- V_ACTIVE, 768, visible lines per frame
- V_SYNC_START, 771, first vcount with vsync asserted
- V_SYNC_END, 777, first vcount after vsync
- V_TOTAL, 806, lines per frame (vcount wraps at V_TOTAL-1)

Ports:
- clockin  in  1  65 MHz pixel clock
- reset  in  1  synchronous, active-high reset
- hand1x_in  in  11  raw user hand 1 x
- hand1y_in  in  10  raw user hand 1 y
- hand2x_in  in  11  raw user hand 2 x
- hand2y_in  in  10  raw user hand 2 y
- hands_valid  in  1  raw hand positions are valid this cycle
- grab1_in  in  1  user grab button 1, asynchronous
- grab2_in  in  1  user grab button 2, asynchronous
- existsout  out  1  constant 0 (registered)
- infout  out  69  {reset, hcount[10:0], vcount[9:0], hsync, vsync, blank, hand1x[10:0], hand1y[9:0], hand2x[10:0], hand2y[9:0], grab2, grab1}; grab1 = bit 0, reset = bit 68
- clockout  out  1  equals clockin (pass-through)

Behaviour:
- One clock; reset is synchronous and active-high. Clock and reset ports are named clockin and reset.
- All infout fields and existsout are registered. There is no combinational path from any input to infout.
- Reset values: hcount=0, vcount=0, hsync=1, vsync=1, blank=0, all hand fields 0, grab1=grab2=0, existsout=0, infout[68]=1.
- After reset deasserts, infout[68] falls one cycle later.
- Sync polarity: active low (0 during sync).
- Reset mid-frame forces the counters to 0/0 on the next edge. Raster restarts cleanly.
- Raster counters:
  - hcount increments every cycle and wraps from H_TOTAL-1 to 0.
  - vcount increments only on an hcount wrap and wraps from V_TOTAL-1 to 0.
- Sync and blank are registered alongside the counters, so each cycle's bus fields are mutually consistent:
  - hsync = 0 iff H_SYNC_START <= hcount < H_SYNC_END.
  - vsync = 0 iff V_SYNC_START <= vcount < V_SYNC_END.
  - blank = 1 iff hcount >= H_ACTIVE or vcount >= V_ACTIVE.
- Hand capture:
  - Shadow registers load from the raw inputs on any cycle where hands_valid=1.
  - If hands_valid=0, the shadow registers hold their value.
- Frame latch: on the cycle where the next (hcount, vcount) is (0, 0), the bus hand fields load from the shadow registers, clamped as below. The new values first appear on infout together with hcount=0, vcount=0.
  - Fields are constant for the entire frame. Downstream stages rely on this.
- Clamping: x > H_ACTIVE-1 becomes H_ACTIVE-1; y > V_ACTIVE-1 becomes V_ACTIVE-1. Unsigned compare, no wrap.
- If hands_valid and the frame latch coincide, the incoming raw value is used (bypass).
- Grab inputs:
  - Each passes through a 2-flop synchroniser.
  - Then a debounce counter: the stable state changes only after 16 consecutive equal synchronised samples.
  - The debounced state is latched into the bus grab bits at the same frame latch as the hands.
- Outputs during reset: infout carries the reset values above and the frame latch is inhibited.

Decomposition:
- Shared package:
  - bus field offsets and widths (BUS_W=69, RESET_BIT=68, HCOUNT_LSB, …, GRAB1_BIT=0)
  - XVGA timing constants
  - a bus pack function used by all stages
- Sub-module xvga_timing: counters plus sync and blank, registered.
- Debounce is a generate loop over two instances of grab_debounce.

Test Plan:
- Reset for 3 cycles, then run -> infout[68] 1 during reset and 0 one cycle after release. hcount steps 0,1,2… Line wraps 1343->0 with vcount 0->1. Frame wraps vcount 805->0.
- Sample hsync and vsync -> hsync=0 exactly for hcount 1048..1183. vsync=0 exactly for vcount 771..776. blank=1 at hcount=1024/vcount=0 and at hcount=0/vcount=768; blank=0 at 1023/767.
- hands_valid pulse with hand1x=500 mid-frame -> bus hand1x unchanged until the next (0,0), then reads 500 for the whole frame.
- hand1x_in=1500 and hand2y_in=900 -> bus hand1x=1023 and hand2y=767.
- grab1_in toggled high for 10 cycles -> no change on the bus. Held high for 20 cycles -> bus grab1=1 from the next frame start.
- Reset asserted at hcount=700, vcount=300 -> the next cycle shows hcount=0, vcount=0, hand fields 0, grab bits 0. existsout is 0 throughout.

Source files
------------

// File: rtl/info_bus_source_pkg.sv
// Shared definitions for the video info bus: field layout, XVGA timing and the bus pack function.
package info_bus_source_pkg;

  localparam int BUS_W      = 69;
  localparam int RESET_BIT  = 68;
  localparam int HCOUNT_LSB = 57;
  localparam int VCOUNT_LSB = 47;
  localparam int HSYNC_BIT  = 46;
  localparam int VSYNC_BIT  = 45;
  localparam int BLANK_BIT  = 44;
  localparam int HAND1X_LSB = 33;
  localparam int HAND1Y_LSB = 23;
  localparam int HAND2X_LSB = 12;
  localparam int HAND2Y_LSB = 2;
  localparam int GRAB2_BIT  = 1;
  localparam int GRAB1_BIT  = 0;

  localparam logic [10:0] XVGA_H_ACTIVE     = 11'd1024;
  localparam logic [10:0] XVGA_H_SYNC_START = 11'd1048;
  localparam logic [10:0] XVGA_H_SYNC_END   = 11'd1184;
  localparam logic [10:0] XVGA_H_TOTAL      = 11'd1344;
  localparam logic [9:0]  XVGA_V_ACTIVE     = 10'd768;
  localparam logic [9:0]  XVGA_V_SYNC_START = 10'd771;
  localparam logic [9:0]  XVGA_V_SYNC_END   = 10'd777;
  localparam logic [9:0]  XVGA_V_TOTAL      = 10'd806;

  localparam int GRAB_DB_LEN = 16;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
  } hand_t;

  function automatic logic [BUS_W-1:0] pack_info(
    input logic        rst,
    input logic [10:0] hcount,
    input logic [9:0]  vcount,
    input logic        hsync,
    input logic        vsync,
    input logic        blank,
    input hand_t       hand1,
    input hand_t       hand2,
    input logic        grab2,
    input logic        grab1
  );
    return {rst, hcount, vcount, hsync, vsync, blank,
            hand1.x, hand1.y, hand2.x, hand2.y, grab2, grab1};
  endfunction

endpackage

// File: rtl/info_bus_source_grab_debounce.sv
// Two-flop synchroniser followed by a down-counter debounce for one grab button.
module grab_debounce #(
  parameter int DB_LEN = 16
) (
  input  logic vclock,
  input  logic reset,
  input  logic grab_async,
  output logic grab_stable
);

  localparam int CW = $clog2(DB_LEN);
  localparam logic [CW-1:0] TC_LOAD = CW'(DB_LEN - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  // Stable state flips on the DB_LEN-th consecutive differing sample.
  always_ff @(posedge vclock) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      grab_stable <= 1'b0;
      cnt         <= TC_LOAD;
    end else begin
      sync1 <= grab_async;
      sync2 <= sync1;
      if (sync2 == grab_stable) begin
        cnt <= TC_LOAD;
      end else if (cnt == '0) begin
        grab_stable <= sync2;
        cnt         <= TC_LOAD;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/info_bus_source_xvga_timing.sv
// XVGA raster counters with sync and blank registered from the same next-state values.
module xvga_timing
  import info_bus_source_pkg::*;
#(
  parameter logic [10:0] H_ACTIVE     = XVGA_H_ACTIVE,
  parameter logic [10:0] H_SYNC_START = XVGA_H_SYNC_START,
  parameter logic [10:0] H_SYNC_END   = XVGA_H_SYNC_END,
  parameter logic [10:0] H_TOTAL      = XVGA_H_TOTAL,
  parameter logic [9:0]  V_ACTIVE     = XVGA_V_ACTIVE,
  parameter logic [9:0]  V_SYNC_START = XVGA_V_SYNC_START,
  parameter logic [9:0]  V_SYNC_END   = XVGA_V_SYNC_END,
  parameter logic [9:0]  V_TOTAL      = XVGA_V_TOTAL
) (
  input  logic        vclock,
  input  logic        reset,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start
);

  logic [10:0] hcount_nxt;
  logic [9:0]  vcount_nxt;
  logic        h_wrap;

  always_comb begin
    h_wrap     = (hcount == H_TOTAL - 11'd1);
    hcount_nxt = h_wrap ? 11'd0 : hcount + 11'd1;
    vcount_nxt = vcount;
    if (h_wrap) vcount_nxt = (vcount == V_TOTAL - 10'd1) ? 10'd0 : vcount + 10'd1;
    // Asserted on the edge that will present (0,0); never during reset.
    frame_start = !reset && (hcount_nxt == 11'd0) && (vcount_nxt == 10'd0);
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      hcount <= 11'd0;
      vcount <= 10'd0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      blank  <= 1'b0;
    end else begin
      hcount <= hcount_nxt;
      vcount <= vcount_nxt;
      hsync  <= !((hcount_nxt >= H_SYNC_START) && (hcount_nxt < H_SYNC_END));
      vsync  <= !((vcount_nxt >= V_SYNC_START) && (vcount_nxt < V_SYNC_END));
      blank  <= (hcount_nxt >= H_ACTIVE) || (vcount_nxt >= V_ACTIVE);
    end
  end

endmodule

// File: rtl/info_bus_source.sv
// Head of the video pipeline: raster timing plus frame-stable hand/grab state packed onto the info bus.
module info_bus_source
  import info_bus_source_pkg::*;
#(
  parameter logic [10:0] H_ACTIVE     = XVGA_H_ACTIVE,
  parameter logic [10:0] H_SYNC_START = XVGA_H_SYNC_START,
  parameter logic [10:0] H_SYNC_END   = XVGA_H_SYNC_END,
  parameter logic [10:0] H_TOTAL      = XVGA_H_TOTAL,
  parameter logic [9:0]  V_ACTIVE     = XVGA_V_ACTIVE,
  parameter logic [9:0]  V_SYNC_START = XVGA_V_SYNC_START,
  parameter logic [9:0]  V_SYNC_END   = XVGA_V_SYNC_END,
  parameter logic [9:0]  V_TOTAL      = XVGA_V_TOTAL
) (
  input  logic             clockin,
  input  logic             reset,
  input  logic [10:0]      hand1x_in,
  input  logic [9:0]       hand1y_in,
  input  logic [10:0]      hand2x_in,
  input  logic [9:0]       hand2y_in,
  input  logic             hands_valid,
  input  logic             grab1_in,
  input  logic             grab2_in,
  output logic             existsout,
  output logic [BUS_W-1:0] infout,
  output logic             clockout
);

  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, blank, frame_start;
  logic [1:0]  grab_raw, grab_stable, bus_grab;
  logic        reset_q;
  hand_t       raw1, raw2, shadow1, shadow2, src1, src2, bus1, bus2;

  xvga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_SYNC_START(H_SYNC_START), .H_SYNC_END(H_SYNC_END), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_SYNC_START(V_SYNC_START), .V_SYNC_END(V_SYNC_END), .V_TOTAL(V_TOTAL)
  ) u_timing (
    .vclock(clockin), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank), .frame_start(frame_start)
  );

  assign grab_raw = {grab2_in, grab1_in};

  for (genvar i = 0; i < 2; i++) begin : g_grab
    grab_debounce #(.DB_LEN(GRAB_DB_LEN)) u_debounce (
      .vclock(clockin), .reset(reset), .grab_async(grab_raw[i]), .grab_stable(grab_stable[i])
    );
  end

  function automatic hand_t clamp_hand(input hand_t h);
    hand_t c;
    c.x = (h.x > H_ACTIVE - 11'd1) ? H_ACTIVE - 11'd1 : h.x;
    c.y = (h.y > V_ACTIVE - 10'd1) ? V_ACTIVE - 10'd1 : h.y;
    return c;
  endfunction

  assign raw1 = '{x: hand1x_in, y: hand1y_in};
  assign raw2 = '{x: hand2x_in, y: hand2y_in};
  // A valid sample on the latch edge bypasses the shadow.
  assign src1 = hands_valid ? raw1 : shadow1;
  assign src2 = hands_valid ? raw2 : shadow2;

  always_ff @(posedge clockin) begin
    reset_q   <= reset;
    existsout <= 1'b0;
    if (reset) begin
      shadow1  <= '0;
      shadow2  <= '0;
      bus1     <= '0;
      bus2     <= '0;
      bus_grab <= '0;
    end else begin
      if (hands_valid) begin
        shadow1 <= raw1;
        shadow2 <= raw2;
      end
      if (frame_start) begin
        bus1     <= clamp_hand(src1);
        bus2     <= clamp_hand(src2);
        bus_grab <= grab_stable;
      end
    end
  end

  assign infout   = pack_info(reset_q, hcount, vcount, hsync, vsync, blank,
                              bus1, bus2, bus_grab[1], bus_grab[0]);
  assign clockout = clockin;

endmodule

// File: tb/tb_info_bus_source.sv
// Randomized bench for info_bus_source against a frame-level reference model (shortened frame height).
module tb_info_bus_source;
  import info_bus_source_pkg::*;

  localparam int HA = 1024, HSS = 1048, HSE = 1184, HT = 1344;
  localparam int VA = 4, VSS = 5, VSE = 7, VT = 8;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst, hv, g1, g2;
  logic [10:0] h1x, h2x;
  logic [9:0]  h1y, h2y;
  logic        existsout, clockout;
  logic [68:0] infout;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          m_t = 0;
  logic        m_rbit = 1'b1;
  logic [10:0] m_h1x, m_h2x, m_s1x, m_s2x;
  logic [9:0]  m_h1y, m_h2y, m_s1y, m_s2y;
  logic        m_g1, m_g2;
  logic        m_deb [2];
  logic        m_last[2];
  int          m_run [2];

  info_bus_source #(
    .V_ACTIVE(10'(VA)), .V_SYNC_START(10'(VSS)), .V_SYNC_END(10'(VSE)), .V_TOTAL(10'(VT))
  ) dut (
    .clockin(clk), .reset(rst),
    .hand1x_in(h1x), .hand1y_in(h1y), .hand2x_in(h2x), .hand2y_in(h2y),
    .hands_valid(hv), .grab1_in(g1), .grab2_in(g2),
    .existsout(existsout), .infout(infout), .clockout(clockout)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [10:0] clx(input logic [10:0] x);
    return (int'(x) > HA - 1) ? 11'(HA - 1) : x;
  endfunction

  function automatic logic [9:0] cly(input logic [9:0] y);
    return (int'(y) > VA - 1) ? 10'(VA - 1) : y;
  endfunction

  function automatic logic [68:0] exp_bus();
    int h, v;
    logic hs, vs, bl;
    h  = m_t % HT;
    v  = (m_t / HT) % VT;
    hs = !(h >= HSS && h < HSE);
    vs = !(v >= VSS && v < VSE);
    bl = (h >= HA) || (v >= VA);
    return {m_rbit, 11'(h), 10'(v), hs, vs, bl, m_h1x, m_h1y, m_h2x, m_h2y, m_g2, m_g1};
  endfunction

  task automatic tick();
    logic gin[2];
    @(posedge clk);
    gin[0] = g1;
    gin[1] = g2;
    if (rst) begin
      m_t = 0; m_rbit = 1'b1;
      m_h1x = '0; m_h1y = '0; m_h2x = '0; m_h2y = '0;
      m_s1x = '0; m_s1y = '0; m_s2x = '0; m_s2y = '0;
      m_g1 = 1'b0; m_g2 = 1'b0;
      for (int i = 0; i < 2; i++) begin m_deb[i] = 1'b0; m_last[i] = 1'b0; m_run[i] = 0; end
    end else begin
      m_rbit = 1'b0;
      m_t++;
      if (m_t % FRAME == 0) begin
        m_h1x = clx(hv ? h1x : m_s1x);
        m_h1y = cly(hv ? h1y : m_s1y);
        m_h2x = clx(hv ? h2x : m_s2x);
        m_h2y = cly(hv ? h2y : m_s2y);
        m_g1  = m_deb[0];
        m_g2  = m_deb[1];
      end
      if (hv) begin m_s1x = h1x; m_s1y = h1y; m_s2x = h2x; m_s2y = h2y; end
      for (int i = 0; i < 2; i++) begin
        m_run[i]  = (gin[i] == m_last[i]) ? m_run[i] + 1 : 1;
        m_last[i] = gin[i];
        if (m_run[i] >= 16) m_deb[i] = gin[i];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; hv = 1'b0; g1 = 1'b0; g2 = 1'b0;
    h1x = '0; h1y = '0; h2x = '0; h2y = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (infout !== exp_bus()) begin n_fail++; $display("FAIL reset_bus: got %h expected %h", infout, exp_bus()); end
      n_checks++;
      if (infout[RESET_BIT] !== 1'b1) begin n_fail++; $display("FAIL reset_bit_high: got %b expected 1", infout[RESET_BIT]); end
      n_checks++;
      if (existsout !== 1'b0) begin n_fail++; $display("FAIL existsout_reset: got %b expected 0", existsout); end
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (infout[RESET_BIT] !== 1'b0) begin n_fail++; $display("FAIL reset_bit_release: got %b expected 0", infout[RESET_BIT]); end
    n_checks++;
    if (infout[HCOUNT_LSB +: 11] !== 11'd1) begin n_fail++; $display("FAIL hcount_first: got %0d expected 1", infout[HCOUNT_LSB +: 11]); end
    n_checks++;
    if (infout !== exp_bus()) begin n_fail++; $display("FAIL release_bus: got %h expected %h", infout, exp_bus()); end
  endtask

  task automatic test_raster_line();
    logic        found = 1'b0;
    logic [10:0] h;
    for (int k = 0; k < 2 * HT; k++) begin
      tick();
      h = infout[HCOUNT_LSB +: 11];
      n_checks++;
      if (infout !== exp_bus()) begin n_fail++; $display("FAIL line_bus: got %h expected %h", infout, exp_bus()); end
      if (h == 11'd1047 || h == 11'd1184) begin
        n_checks++;
        if (infout[HSYNC_BIT] !== 1'b1) begin n_fail++; $display("FAIL hsync_outside h=%0d: got %b expected 1", h, infout[HSYNC_BIT]); end
      end
      if (h == 11'd1048 || h == 11'd1183) begin
        n_checks++;
        if (infout[HSYNC_BIT] !== 1'b0) begin n_fail++; $display("FAIL hsync_inside h=%0d: got %b expected 0", h, infout[HSYNC_BIT]); end
      end
      if (h == 11'd1023 || h == 11'd1024) begin
        n_checks++;
        if (infout[BLANK_BIT] !== (h == 11'd1024)) begin n_fail++; $display("FAIL blank_h h=%0d: got %b expected %b", h, infout[BLANK_BIT], h == 11'd1024); end
      end
      if (m_t % HT == HT - 1) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL line_end_timeout: got no line end expected one within %0d cycles", 2 * HT); end
    tick();
    n_checks++;
    if (infout[HCOUNT_LSB +: 11] !== 11'd0 || infout[VCOUNT_LSB +: 10] !== 10'd1) begin
      n_fail++; $display("FAIL line_wrap: got h=%0d v=%0d expected h=0 v=1", infout[HCOUNT_LSB +: 11], infout[VCOUNT_LSB +: 10]);
    end
  endtask

  task automatic test_hand_capture();
    logic        found = 1'b0;
    logic [10:0] h, ph = '0;
    logic [9:0]  v, pv = '0;
    for (int k = 0; k < FRAME + 10; k++) begin
      hv = (k == 100);
      if (k == 100) begin
        h1x = 11'd500; h1y = 10'($urandom_range(0, 1023));
        h2x = 11'($urandom_range(0, 2047)); h2y = 10'($urandom_range(0, 1023));
      end else if (k == 101) begin
        h1x = 11'($urandom_range(0, 2047)); h1y = 10'($urandom_range(0, 1023));
      end
      tick();
      h = infout[HCOUNT_LSB +: 11];
      v = infout[VCOUNT_LSB +: 10];
      n_checks++;
      if (infout !== exp_bus()) begin n_fail++; $display("FAIL capture_bus: got %h expected %h", infout, exp_bus()); end
      if (h == 11'd0 && (v == 10'(VSS - 1) || v == 10'(VSS) || v == 10'(VSE - 1) || v == 10'(VSE))) begin
        n_checks++;
        if (infout[VSYNC_BIT] !== !(v == 10'(VSS) || v == 10'(VSE - 1))) begin
          n_fail++; $display("FAIL vsync v=%0d: got %b", v, infout[VSYNC_BIT]);
        end
      end
      if ((h == 11'd0 && v == 10'(VA)) || (h == 11'd1023 && v == 10'(VA - 1))) begin
        n_checks++;
        if (infout[BLANK_BIT] !== (v == 10'(VA))) begin n_fail++; $display("FAIL blank_v h=%0d v=%0d: got %b", h, v, infout[BLANK_BIT]); end
      end
      if (m_t % FRAME == 0) begin found = 1'b1; break; end
      n_checks++;
      if (infout[HAND1X_LSB +: 11] !== 11'd0) begin n_fail++; $display("FAIL hand1x_early: got %0d expected 0", infout[HAND1X_LSB +: 11]); end
      ph = h; pv = v;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL frame_timeout: got no frame start expected one within %0d cycles", FRAME); end
    n_checks++;
    if (ph !== 11'd1343 || pv !== 10'(VT - 1)) begin n_fail++; $display("FAIL frame_wrap_prev: got h=%0d v=%0d expected h=1343 v=%0d", ph, pv, VT - 1); end
    n_checks++;
    if (infout[HCOUNT_LSB +: 21] !== 21'd0) begin n_fail++; $display("FAIL frame_wrap: got %h expected 0", infout[HCOUNT_LSB +: 21]); end
    n_checks++;
    if (infout[HAND1X_LSB +: 11] !== 11'd500) begin n_fail++; $display("FAIL hand1x_latched: got %0d expected 500", infout[HAND1X_LSB +: 11]); end
  endtask

  task automatic test_clamp_grab();
    logic found = 1'b0;
    for (int k = 0; k < FRAME + 10; k++) begin
      hv = (k == 1000);
      if (k == 1000) begin
        h1x = 11'd1500; h2y = 10'd900;
        h1y = 10'($urandom_range(0, 1023)); h2x = 11'($urandom_range(0, 2047));
      end
      if (k == 3000) g1 = 1'b1;
      tick();
      n_checks++;
      if (infout !== exp_bus()) begin n_fail++; $display("FAIL clamp_bus: got %h expected %h", infout, exp_bus()); end
      if (m_t % FRAME == 0) begin found = 1'b1; break; end
      n_checks++;
      if (infout[HAND1X_LSB +: 11] !== 11'd500 || infout[GRAB1_BIT] !== 1'b0) begin
        n_fail++; $display("FAIL frame_stable: got hand1x=%0d grab1=%b expected 500/0", infout[HAND1X_LSB +: 11], infout[GRAB1_BIT]);
      end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL clamp_timeout: got no frame start expected one within %0d cycles", FRAME); end
    n_checks++;
    if (infout[HAND1X_LSB +: 11] !== 11'd1023) begin n_fail++; $display("FAIL clamp_x: got %0d expected 1023", infout[HAND1X_LSB +: 11]); end
    n_checks++;
    if (infout[HAND2Y_LSB +: 10] !== 10'(VA - 1)) begin n_fail++; $display("FAIL clamp_y: got %0d expected %0d", infout[HAND2Y_LSB +: 10], VA - 1); end
    n_checks++;
    if (infout[GRAB1_BIT] !== 1'b1) begin n_fail++; $display("FAIL grab1_held: got %b expected 1", infout[GRAB1_BIT]); end
  endtask

  task automatic test_bypass_random();
    logic found = 1'b0;
    for (int k = 0; k < FRAME + 10; k++) begin
      if ((m_t + 1) % FRAME == 0) begin
        hv = 1'b1; h1x = 11'd777; h1y = 10'd2; h2x = 11'd1100; h2y = 10'd1;
      end else begin
        hv  = ($urandom_range(0, 63) == 0);
        h1x = 11'($urandom_range(0, 2047)); h1y = 10'($urandom_range(0, 1023));
        h2x = 11'($urandom_range(0, 2047)); h2y = 10'($urandom_range(0, 1023));
      end
      if (k == 100)  g1 = 1'b0;
      if (k == 2000) g2 = 1'b1;
      if (k == 5000) g1 = 1'b1;
      if (k == 5010) g1 = 1'b0;
      tick();
      n_checks++;
      if (infout !== exp_bus()) begin n_fail++; $display("FAIL random_bus: got %h expected %h", infout, exp_bus()); end
      if (m_t % FRAME == 0) begin found = 1'b1; break; end
    end
    hv = 1'b0;
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL bypass_timeout: got no frame start expected one within %0d cycles", FRAME); end
    n_checks++;
    if (infout[HAND1X_LSB +: 11] !== 11'd777 || infout[HAND2X_LSB +: 11] !== 11'd1023) begin
      n_fail++; $display("FAIL bypass: got hand1x=%0d hand2x=%0d expected 777/1023", infout[HAND1X_LSB +: 11], infout[HAND2X_LSB +: 11]);
    end
    n_checks++;
    if (infout[GRAB1_BIT] !== 1'b0 || infout[GRAB2_BIT] !== 1'b1) begin
      n_fail++; $display("FAIL grab_pulse: got grab1=%b grab2=%b expected 0/1", infout[GRAB1_BIT], infout[GRAB2_BIT]);
    end
  endtask

  task automatic test_mid_reset();
    logic found = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      tick();
      n_checks++;
      if (infout !== exp_bus()) begin n_fail++; $display("FAIL pre_reset_bus: got %h expected %h", infout, exp_bus()); end
      if (m_t % HT == 700 && (m_t / HT) % VT == 2) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL mid_reset_timeout: got no h=700 v=2 expected one"); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (infout !== {1'b1, 21'd0, 3'b110, 42'd0, 2'b00}) begin
      n_fail++; $display("FAIL mid_reset: got %h expected %h", infout, {1'b1, 21'd0, 3'b110, 44'd0});
    end
    n_checks++;
    if (existsout !== 1'b0) begin n_fail++; $display("FAIL existsout_mid: got %b expected 0", existsout); end
    for (int k = 0; k < 50; k++) begin
      tick();
      n_checks++;
      if (infout !== exp_bus()) begin n_fail++; $display("FAIL restart_bus: got %h expected %h", infout, exp_bus()); end
    end
    n_checks++;
    if (infout[HCOUNT_LSB +: 11] !== 11'd50 || clockout !== clk) begin
      n_fail++; $display("FAIL restart: got h=%0d clockout=%b expected 50/%b", infout[HCOUNT_LSB +: 11], clockout, clk);
    end
  endtask

  initial begin
    test_reset();
    test_raster_line();
    test_hand_capture();
    test_clamp_grab();
    test_bypass_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
